channelizer_512_frame_reverse_ctrl: RTL and testbench

Ping-pong sequencer for the 512-point frame-reversal dual-port RAM between the polyphase FIR output stream and the IFFT input stream. Port A is the write side: it writes each incoming frame in ascending order into one RAM bank. Port B is the read side: it reads the other, completed bank in descending order. The controller handles AXI-stream style valid/ready on both sides, bank swapping, last-flag generation and frame-length checking, so input and output frames overlap at full rate.

---
 rtl/channelizer_512_frame_reverse_ctrl.sv | 99 +++++++++
 tb/tb_channelizer_512_frame_reverse_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channelizer_512_frame_reverse_ctrl.sv
// Ping-pong controller for the frame-reversal dual-port RAM.
// Port A writes each incoming frame in ascending order into one bank.
// Port B reads the other, completed bank in descending order.
// Both streams use valid/ready: a beat transfers on a clk_1 edge where
// valid, ready and ce_1 are all 1. A sender keeps valid and its data
// stable until the beat transfers.
module channelizer_512_frame_reverse_ctrl #(
    parameter int FRAME_LEN = 512,
    parameter int ADDR_W    = 9
) (
    input  logic              clk_1,
    input  logic              reset_in,
    input  logic              ce_1,
    input  logic              valid_in,
    input  logic              last_in,
    output logic              ready_in,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic              rd_en,
    output logic [ADDR_W:0]   rd_addr,
    input  logic              ready_out,
    output logic              valid_out,
    output logic              last_out,
    output logic              frame_err,
    output logic [1:0]        bank_full
);

    localparam logic [ADDR_W-1:0] CNT_MAX = ADDR_W'(FRAME_LEN - 1);

    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] rd_cnt;
    logic              wbank;
    logic              rbank;
    logic              wr_last;
    logic              rd_last;
    logic [1:0]        set_mask;
    logic [1:0]        clr_mask;

    // Handshakes, RAM addressing and the per-bank full flag updates.
    // A full write bank stalls the writer; an empty read bank stalls the
    // reader, so set and clear never hit the same bank in one cycle.
    always_comb begin
        ready_in = ~bank_full[wbank] & ~reset_in;
        wr_en    = valid_in & ready_in & ce_1;
        rd_en    = ce_1 & bank_full[rbank] & (~valid_out | ready_out);
        wr_last  = (wr_cnt == CNT_MAX);
        rd_last  = (rd_cnt == CNT_MAX);
        wr_addr  = {wbank, wr_cnt};
        rd_addr  = {rbank, CNT_MAX - rd_cnt};
        set_mask = 2'b00;
        clr_mask = 2'b00;
        if (wr_en && wr_last) begin
            set_mask[wbank] = 1'b1;
        end
        if (rd_en && rd_last) begin
            clr_mask[rbank] = 1'b1;
        end
    end

    // Counters, bank pointers, full flags and the output register.
    // The output register tracks the RAM port B output register: a stalled
    // beat keeps rd_en low, so RAM data and last_out hold together.
    always_ff @(posedge clk_1) begin
        if (reset_in) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            bank_full <= 2'b00;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            frame_err <= 1'b0;
        end else if (ce_1) begin
            if (wr_en) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_last) begin
                    wbank <= ~wbank;
                end
            end
            if (rd_en) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_last) begin
                    rbank <= ~rbank;
                end
            end
            bank_full <= (bank_full | set_mask) & ~clr_mask;
            // Frame length is defined by the counter alone; last_in is only checked.
            frame_err <= wr_en & (last_in != wr_last);
            if (rd_en) begin
                valid_out <= 1'b1;
                last_out  <= rd_last;
            end else if (ready_out) begin
                valid_out <= 1'b0;
                last_out  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_channelizer_512_frame_reverse_ctrl.sv
// Bench for the frame-reversal controller at FRAME_LEN=8.
// A RAM model sits between the address ports; a frame-level model predicts
// the reversed output stream, the RAM addresses and the frame_err pulses.
module tb_channelizer_512_frame_reverse_ctrl;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int DW = 16;

    logic          clk;
    logic          reset_in;
    logic          ce_1;
    logic          valid_in;
    logic          last_in;
    logic          ready_in;
    logic          wr_en;
    logic [AW:0]   wr_addr;
    logic          rd_en;
    logic [AW:0]   rd_addr;
    logic          ready_out;
    logic          valid_out;
    logic          last_out;
    logic          frame_err;
    logic [1:0]    bank_full;
    logic [DW-1:0] data_in;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] mem [0:2*N-1];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model state
    logic [DW:0]   exp_q[$];
    logic [DW:0]   out_log[$];
    logic [AW:0]   addr_q[$];
    logic [DW-1:0] fbuf [0:N-1];
    int            idx        = 0;
    int            frame_cnt  = 0;
    logic          exp_err    = 1'b0;
    int            err_seen   = 0;
    int            stall_cnt  = 0;
    int            last_wr_cyc    = -1;
    int            first_valid_cyc = -1;
    int            last_pop_cyc   = -1;
    logic [29:0]   prev_snap;
    logic          prev_ce    = 1'b1;
    logic          prev_rst   = 1'b1;
    logic          have_prev  = 1'b0;
    logic          t6_done    = 1'b0;

    channelizer_512_frame_reverse_ctrl #(.FRAME_LEN(N), .ADDR_W(AW)) dut (
        .clk_1     (clk),
        .reset_in  (reset_in),
        .ce_1      (ce_1),
        .valid_in  (valid_in),
        .last_in   (last_in),
        .ready_in  (ready_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .last_out  (last_out),
        .frame_err (frame_err),
        .bank_full (bank_full)
    );

    // clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // dual-port RAM with registered port B output
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= data_in;
        if (rd_en) ram_dout <= mem[rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // compare process: check outputs, then advance the model for the next edge
    always @(negedge clk) begin
        logic        acc;
        logic [29:0] snap;
        logic [DW:0] e;
        logic [AW:0] a;
        if (cyc > 0) begin
            acc  = valid_in & ready_in & ce_1;
            snap = {wr_addr, rd_addr, valid_out, last_out, frame_err, bank_full, ready_in, ram_dout};
            if (have_prev && !prev_ce && !prev_rst) chk("ce_hold", snap, prev_snap);
            prev_snap = snap;
            prev_ce   = ce_1;
            prev_rst  = reset_in;
            have_prev = 1'b1;

            if (valid_out) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_valid_out");
                end else begin
                    chk("out_last_data", {last_out, ram_dout}, exp_q[0]);
                    if (ready_out && ce_1) begin
                        e = exp_q.pop_front();
                        out_log.push_back(e);
                        last_pop_cyc = cyc;
                    end
                end
            end
            chk("frame_err", frame_err, exp_err);
            if (frame_err) err_seen++;
            if (reset_in) chk("ready_in_in_reset", ready_in, 0);
            chk("wr_en", wr_en, acc);
            if (!ce_1) chk("rd_en_ce_off", rd_en, 0);
            if (valid_out && !ready_out) chk("rd_en_stalled", rd_en, 0);
            if (rd_en) begin
                if (addr_q.size() == 0) fail_now("rd_en_without_frame");
                else begin
                    a = addr_q.pop_front();
                    chk("rd_addr", rd_addr, a);
                end
            end
            if (acc) chk("wr_addr", wr_addr, {frame_cnt[0], AW'(idx)});

            if (reset_in) begin
                exp_q.delete();
                addr_q.delete();
                idx       = 0;
                frame_cnt = 0;
                exp_err   = 1'b0;
            end else if (ce_1) begin
                exp_err = acc && (last_in != (idx == N - 1));
                if (acc) begin
                    fbuf[idx] = data_in;
                    if (idx == N - 1) begin
                        for (int k = N - 1; k >= 0; k--) exp_q.push_back({k == 0, fbuf[k]});
                        for (int k = 0; k < N; k++) addr_q.push_back({frame_cnt[0], AW'(N - 1 - k)});
                        frame_cnt++;
                        if (last_wr_cyc < 0) last_wr_cyc = cyc;
                        idx = 0;
                    end else begin
                        idx++;
                    end
                end
            end
        end
    end

    // driver: hold one sample until accepted
    task automatic send(input logic [DW-1:0] d, input logic l);
        int   t;
        logic acc;
        valid_in = 1'b1;
        data_in  = d;
        last_in  = l;
        t   = 0;
        acc = 1'b0;
        while (!acc && t < 300) begin
            @(negedge clk);
            acc = ready_in && ce_1;
            if (!acc) stall_cnt++;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) fail_now("send_timeout");
    endtask

    task automatic idle();
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic send_frame(input int base, input int last_pos);
        for (int i = 0; i < N; i++) send(DW'(base + i), i == last_pos);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || valid_out) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 2000) fail_now("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW:0] held;
        reset_in  = 1'b1;
        ce_1      = 1'b1;
        valid_in  = 1'b0;
        last_in   = 1'b0;
        data_in   = '0;
        ready_out = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid_out", valid_out, 0);
        chk("reset_last_out", last_out, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_bank_full", bank_full, 0);
        chk("reset_ready_in", ready_in, 0);
        @(posedge clk);
        #1;
        reset_in = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", ready_in, 1);
        @(posedge clk);
        #1;

        // single frame 0..7
        out_log.delete();
        send_frame(0, 7);
        idle();
        wait_drain();
        chk("t1_count", out_log.size(), 8);
        chk("t1_first", out_log[0], {1'b0, 16'd7});
        chk("t1_mid", out_log[3], {1'b0, 16'd4});
        chk("t1_last", out_log[7], {1'b1, 16'd0});
        chk("t1_latency", first_valid_cyc - last_wr_cyc, 2);

        // three back-to-back frames
        out_log.delete();
        first_valid_cyc = -1;
        stall_cnt = 0;
        send_frame(0, 7);
        send_frame(8, 7);
        send_frame(16, 7);
        idle();
        chk("t2_no_input_stall", stall_cnt, 0);
        wait_drain();
        chk("t2_count", out_log.size(), 24);
        chk("t2_f1_first", out_log[8], {1'b0, 16'd15});
        chk("t2_f2_last", out_log[23], {1'b1, 16'd16});
        chk("t2_no_gap", last_pop_cyc - first_valid_cyc + 1, 24);

        // downstream stall for 20 cycles during the second frame
        out_log.delete();
        send_frame(100, 7);
        send(200, 1'b0);
        send(201, 1'b0);
        fork
            begin
                for (int i = 2; i < N; i++) send(DW'(200 + i), i == N - 1);
                send_frame(300, 7);
                idle();
            end
            begin
                ready_out = 1'b0;
                @(posedge clk);
                #1;
                held = {last_out, ram_dout};
                chk("t3_valid_held", valid_out, 1);
                repeat (17) @(posedge clk);
                #1;
                chk("t3_both_full", bank_full, 2'b11);
                chk("t3_ready_in_low", ready_in, 0);
                chk("t3_data_held", {last_out, ram_dout}, held);
                repeat (2) @(posedge clk);
                #1;
                ready_out = 1'b1;
            end
        join
        wait_drain();
        chk("t3_count", out_log.size(), 24);
        chk("t3_a_first", out_log[0], {1'b0, 16'd107});
        chk("t3_b_last", out_log[15], {1'b1, 16'd200});
        chk("t3_c_first", out_log[16], {1'b0, 16'd307});

        // misplaced last_in
        out_log.delete();
        err_seen = 0;
        send_frame(40, 5);
        idle();
        wait_drain();
        chk("t4_err_pulses", err_seen, 2);
        chk("t4_first", out_log[0], {1'b0, 16'd47});
        chk("t4_last", out_log[7], {1'b1, 16'd40});

        // reset mid-frame while the previous frame drains
        send_frame(400, 7);
        send(500, 1'b0);
        send(501, 1'b0);
        send(502, 1'b0);
        idle();
        reset_in = 1'b1;
        @(negedge clk);
        chk("t5_ready_in_reset", ready_in, 0);
        @(posedge clk);
        #1;
        reset_in = 1'b0;
        @(negedge clk);
        chk("t5_valid_out", valid_out, 0);
        chk("t5_last_out", last_out, 0);
        chk("t5_frame_err", frame_err, 0);
        chk("t5_bank_full", bank_full, 0);
        @(posedge clk);
        #1;
        out_log.delete();
        send_frame(600, 7);
        idle();
        wait_drain();
        chk("t5_count", out_log.size(), 8);
        chk("t5_first", out_log[0], {1'b0, 16'd607});
        chk("t5_last", out_log[7], {1'b1, 16'd600});

        // clock enable toggling every cycle, random data
        out_log.delete();
        t6_done = 1'b0;
        fork
            begin
                while (!t6_done) begin
                    @(posedge clk);
                    #1;
                    ce_1 = ~ce_1;
                end
                ce_1 = 1'b1;
            end
            begin
                for (int f = 0; f < 3; f++)
                    for (int i = 0; i < N; i++)
                        send(DW'($urandom_range(0, 65535)), i == N - 1);
                idle();
                wait_drain();
                t6_done = 1'b1;
            end
        join
        wait_drain();
        chk("t6_count", out_log.size(), 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
